// File: rtl/scu_bus_pkg.sv
// scu_bus_pkg: shared response codes, FSM states, fill data and helpers for the bus router
package scu_bus_pkg;
  localparam logic [2:0] RESP_OKAY    = 3'h0;
  localparam logic [2:0] RESP_DECERR  = 3'h2;
  localparam logic [2:0] RESP_TIMEOUT = 3'h3;
  localparam logic [31:0] DEAD_DATA   = 32'hDEAD_DEAD;
  typedef enum logic [1:0] {IDLE, ACCESS, ERR, DONE} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/scu_bus_addr_match.sv
// scu_bus_addr_match: decodes a bus address into per-slave hits, the winning index and its offset
module scu_bus_addr_match #(
  parameter int P_ADDR_W     = 24,
  parameter int P_NUM_SLV    = 4,
  parameter int P_SLV_ADDR_W = 16,
  parameter int P_IDX_W      = (P_NUM_SLV > 1) ? $clog2(P_NUM_SLV) : 1,
  parameter logic [P_NUM_SLV*P_ADDR_W-1:0] P_BASE = '0,
  parameter logic [P_NUM_SLV*P_ADDR_W-1:0] P_SIZE = '0
) (
  input  logic [P_ADDR_W-1:0]     addr_i,
  output logic [P_NUM_SLV-1:0]    hit_o,
  output logic [P_IDX_W-1:0]      idx_o,
  output logic [P_SLV_ADDR_W-1:0] offset_o
);
  for (genvar k = 0; k < P_NUM_SLV; k++) begin : g_hit
    logic [P_ADDR_W:0] lo, hi;
    assign lo = {1'b0, P_BASE[k*P_ADDR_W +: P_ADDR_W]};
    assign hi = lo + {1'b0, P_SIZE[k*P_ADDR_W +: P_ADDR_W]};
    assign hit_o[k] = ({1'b0, addr_i} >= lo) && ({1'b0, addr_i} < hi);
  end
  // scan from the top down so the lowest hitting slave is left in idx_o
  always_comb begin
    idx_o = '0;
    for (int i = P_NUM_SLV - 1; i >= 0; i--) if (hit_o[i]) idx_o = P_IDX_W'(i);
  end
  // offset relative to the winning slave's base, truncated to the slave address width
  always_comb offset_o = P_SLV_ADDR_W'(addr_i - P_BASE[idx_o*P_ADDR_W +: P_ADDR_W]);
endmodule

// File: rtl/scu_bus_slave_router.sv
// scu_bus_slave_router: routes single-outstanding bus requests to address-decoded slaves with timeout
module scu_bus_slave_router
  import scu_bus_pkg::*;
#(
  parameter int P_ADDR_W     = 24,
  parameter int P_RESP_W     = 3,
  parameter int P_NUM_SLV    = 4,
  parameter int P_SLV_ADDR_W = 16,
  parameter logic [P_NUM_SLV*P_ADDR_W-1:0] P_BASE = {24'h01_0000, 24'h00_1000, 24'h00_0800, 24'h00_0000},
  parameter logic [P_NUM_SLV*P_ADDR_W-1:0] P_SIZE = {24'hF_0000, 24'h0F000, 24'h00800, 24'h00040},
  parameter int P_TIMEOUT    = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          bus_csb_i,
  input  logic                          bus_wr_i,
  input  logic [P_ADDR_W-1:0]           bus_address_i,
  input  logic [31:0]                   bus_write_data_i,
  input  logic [3:0]                    bus_byte_en_i,
  output logic [31:0]                   bus_read_data_o,
  output logic                          bus_ready_o,
  output logic [P_RESP_W-1:0]           bus_response_o,
  output logic [P_NUM_SLV-1:0]          slv_csb_o,
  output logic                          slv_wr_o,
  output logic [P_SLV_ADDR_W-1:0]       slv_address_o,
  output logic [31:0]                   slv_write_data_o,
  output logic [3:0]                    slv_byte_en_o,
  input  logic [32*P_NUM_SLV-1:0]       slv_read_data_i,
  input  logic [P_NUM_SLV-1:0]          slv_ready_i,
  input  logic [P_RESP_W*P_NUM_SLV-1:0] slv_response_i,
  output logic [15:0]                   err_cnt_o
);
  localparam int IDX_W = (P_NUM_SLV > 1) ? $clog2(P_NUM_SLV) : 1;
  localparam int CNT_W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  state_t state_q, state_d;
  logic wr_q, wr_d;
  logic [P_SLV_ADDR_W-1:0] addr_q, addr_d, hit_off;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata;
  logic [3:0] be_q, be_d;
  logic [IDX_W-1:0] idx_q, idx_d, hit_idx;
  logic [P_RESP_W-1:0] resp_q, resp_d, sel_resp;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] err_q, err_d;
  logic [P_NUM_SLV-1:0] hit;
  logic sel_ready, timeout;
  scu_bus_addr_match #(
    .P_ADDR_W    (P_ADDR_W),
    .P_NUM_SLV   (P_NUM_SLV),
    .P_SLV_ADDR_W(P_SLV_ADDR_W),
    .P_IDX_W     (IDX_W),
    .P_BASE      (P_BASE),
    .P_SIZE      (P_SIZE)
  ) u_match (
    .addr_i  (bus_address_i),
    .hit_o   (hit),
    .idx_o   (hit_idx),
    .offset_o(hit_off)
  );
  assign sel_ready = slv_ready_i[idx_q];
  assign sel_rdata = slv_read_data_i[idx_q*32 +: 32];
  assign sel_resp  = slv_response_i[idx_q*P_RESP_W +: P_RESP_W];
  assign timeout   = (P_TIMEOUT != 0) && (cnt_q == CNT_W'(P_TIMEOUT - 1));
  // next state: accept in IDLE, wait for the selected slave or the timeout in ACCESS, one-cycle ERR/DONE
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    cnt_d   = (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (!bus_csb_i) begin
        if (|hit) begin
          state_d = ACCESS;
          wr_d    = bus_wr_i;
          addr_d  = hit_off;
          wdata_d = bus_write_data_i;
          be_d    = bus_byte_en_i;
          idx_d   = hit_idx;
        end else begin
          state_d = ERR;
          err_d   = sat_inc(err_q);
        end
      end
      ACCESS: if (sel_ready) begin
        state_d = DONE;
        rdata_d = sel_rdata;
        resp_d  = sel_resp;
      end else if (timeout) begin
        state_d = DONE;
        rdata_d = DEAD_DATA;
        resp_d  = P_RESP_W'(RESP_TIMEOUT);
        err_d   = sat_inc(err_q);
      end
      default: state_d = IDLE;
    endcase
  end
  // registers; reset aborts any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // outputs are decoded from state so slave selects drop the cycle after ready
  always_comb begin
    bus_ready_o      = (state_q == ERR) || (state_q == DONE);
    bus_read_data_o  = (state_q == DONE) ? rdata_q : DEAD_DATA;
    bus_response_o   = (state_q == DONE) ? resp_q :
                       (state_q == ERR) ? P_RESP_W'(RESP_DECERR) : P_RESP_W'(RESP_OKAY);
    slv_csb_o        = (state_q == ACCESS) ? ~(P_NUM_SLV'(1) << idx_q) : '1;
    slv_wr_o         = (state_q == ACCESS) && wr_q;
    slv_address_o    = (state_q == ACCESS) ? addr_q : '0;
    slv_write_data_o = (state_q == ACCESS) ? wdata_q : '0;
    slv_byte_en_o    = (state_q == ACCESS) ? be_q : '0;
    err_cnt_o        = err_q;
  end
endmodule
